commit_checker: RTL and testbench
=================================

COMMIT_CHECKER -- requirements
Module: commit_checker

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set expected-record FIFO depth (power of 2, ≥2).
REQ-002 clk  in  1  single clock; all state SHALL update on posedge clk only.
REQ-003 rst  in  1  synchronous, active-low reset.
REQ-004 exp_valid  in  1  expected record offered (producer side).
REQ-005 exp_ready  out  1  checker accepts record this cycle.
REQ-006 exp_pc, exp_wdata, exp_addr, exp_mdata  in  16 each  expected commit fields.
REQ-007 exp_wreg  in  3; exp_regwrite, exp_memread, exp_memwrite, exp_halt  in  1 each.
REQ-008 ret_valid  in  1  DUT retired one instruction this cycle.
REQ-009 ret_pc, ret_wdata, ret_addr, ret_mdata  in  16; ret_wreg  in  3; ret_regwrite, ret_memread, ret_memwrite, ret_halt  in  1 each.
REQ-010 mismatch  out  1  sticky error flag.
REQ-011 err_field  out  5  bit0 PC, bit1 flags, bit2 reg (wreg/wdata), bit3 mem (addr/mdata), bit4 underflow.
REQ-012 err_inum  out  16  inst_count value of first failing retire.
REQ-013 inst_count  out  16  matched retires; done  out  1  halt matched; occupancy  out  clog2(DEPTH)+1  FIFO fill.

Function
REQ-014 States SHALL be RUN, DONE, FAIL; reset enters RUN.
REQ-015 exp_ready SHALL equal (state==RUN) && !full, registered-only dependence (no path from ret_valid).
REQ-016 Push SHALL occur when exp_valid && exp_ready; record stored whole.
REQ-017 In RUN, ret_valid SHALL pop the FIFO head and compare in the same cycle; compare is combinational, outcome registered at next edge.
REQ-018 Compare: PC always; flags {regwrite,memread,memwrite,halt} always; wreg/wdata only if exp_regwrite; addr if exp_memread or exp_memwrite; mdata only if exp_memwrite.
REQ-019 All fields match: inst_count SHALL increment by 1 (wraps at 16'hFFFF→0); if exp_halt, state→DONE, done=1.
REQ-020 Any field differs: state→FAIL, mismatch=1, err_field=per-bit differences, err_inum=current inst_count; inst_count not incremented.
REQ-021 ret_valid with FIFO empty in RUN: state→FAIL, err_field=5'b10000, no pop.
REQ-022 Simultaneous push and pop: both SHALL occur; occupancy unchanged; push accepted only if not full at cycle start (pop does not free a slot same-cycle).
REQ-023 Push and pop of the same record in one cycle (empty FIFO) SHALL NOT bypass; REQ-021 applies.
REQ-024 In DONE/FAIL: ret_valid ignored, no pushes, no pops; mismatch, err_field, err_inum, inst_count, done held until reset.
REQ-025 FIFO pointers SHALL wrap modulo DEPTH; occupancy counts 0..DEPTH.

Reset
REQ-026 rst==0 at posedge SHALL set: state RUN, FIFO empty, occupancy 0, inst_count 0, mismatch 0, err_field 0, err_inum 0, done 0; exp_ready becomes 1 the cycle after release.
REQ-027 Reset mid-operation SHALL discard stored records; no push/pop/compare in the reset cycle.

Structure
REQ-028 Shared package proc_trace_pkg SHALL hold: commit record struct widths, err_field bit indices, state encoding (RUN=2'd0, DONE=2'd1, FAIL=2'd2).
REQ-029 Sub-module trace_fifo (parameter DEPTH, record-wide data, push/pop/full/empty/occupancy) SHALL hold the FIFO; compare and FSM stay in commit_checker.
REQ-030 Record width SHALL be 16*4+3+4 = 71 bits.

Verification
REQ-031 Push 3 ALU records (pc 0x0000/0x0002/0x0004, regwrite=1, wreg 1..3) then matching retires, then halt record pc 0x0006 -> inst_count=4, done=1, mismatch=0.
REQ-032 Expected wdata 0x1234, retired 0x1235 at 3rd retire -> mismatch=1, err_field=5'b00100, err_inum=2, state FAIL, exp_ready=0.
REQ-033 ret_valid with FIFO empty after reset -> err_field=5'b10000, inst_count=0.
REQ-034 Fill FIFO to 4, hold exp_valid -> exp_ready=0, occupancy=4; then push+retire same cycle at occupancy 3 -> occupancy stays 3.
REQ-035 Store record expected memwrite=1 addr 0x0010 mdata 0xBEEF, retired memwrite=0 -> err_field=5'b01010 (flags+mem).
REQ-036 Assert rst=0 at occupancy 2, inst_count 5 -> next cycle occupancy 0, inst_count 0, exp_ready 0 during reset, 1 after release.

Source files
------------

// File: rtl/commit_checker_pkg.sv
// Shared definitions for the commit-trace checker: record layout, error bits, FSM encoding.
package proc_trace_pkg;

    localparam int REC_W = 16 * 4 + 3 + 4;

    localparam int ERR_PC    = 0;
    localparam int ERR_FLAGS = 1;
    localparam int ERR_REG   = 2;
    localparam int ERR_MEM   = 3;
    localparam int ERR_UNDER = 4;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] wdata;
        logic [15:0] addr;
        logic [15:0] mdata;
        logic [2:0]  wreg;
        logic        regwrite;
        logic        memread;
        logic        memwrite;
        logic        halt;
    } commit_rec_t;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        DONE = 2'd1,
        FAIL = 2'd2
    } state_t;

    // Data fields only count when the expected record says the instruction uses them.
    function automatic logic [4:0] rec_diff(input commit_rec_t e, input commit_rec_t r);
        logic [4:0] d;
        d            = '0;
        d[ERR_PC]    = (e.pc != r.pc);
        d[ERR_FLAGS] = ({e.regwrite, e.memread, e.memwrite, e.halt} !=
                        {r.regwrite, r.memread, r.memwrite, r.halt});
        d[ERR_REG]   = e.regwrite && ((e.wreg != r.wreg) || (e.wdata != r.wdata));
        d[ERR_MEM]   = ((e.memread || e.memwrite) && (e.addr != r.addr)) ||
                       (e.memwrite && (e.mdata != r.mdata));
        return d;
    endfunction

endpackage

// File: rtl/commit_checker_if.sv
// Producer (expected records) and retire-port bundle for the commit checker.
interface commit_checker_if;

    logic        exp_valid;
    logic        exp_ready;
    logic [15:0] exp_pc;
    logic [15:0] exp_wdata;
    logic [15:0] exp_addr;
    logic [15:0] exp_mdata;
    logic [2:0]  exp_wreg;
    logic        exp_regwrite;
    logic        exp_memread;
    logic        exp_memwrite;
    logic        exp_halt;

    logic        ret_valid;
    logic [15:0] ret_pc;
    logic [15:0] ret_wdata;
    logic [15:0] ret_addr;
    logic [15:0] ret_mdata;
    logic [2:0]  ret_wreg;
    logic        ret_regwrite;
    logic        ret_memread;
    logic        ret_memwrite;
    logic        ret_halt;

    modport master (
        output exp_valid, exp_pc, exp_wdata, exp_addr, exp_mdata, exp_wreg,
               exp_regwrite, exp_memread, exp_memwrite, exp_halt,
        output ret_valid, ret_pc, ret_wdata, ret_addr, ret_mdata, ret_wreg,
               ret_regwrite, ret_memread, ret_memwrite, ret_halt,
        input  exp_ready
    );

    modport slave (
        input  exp_valid, exp_pc, exp_wdata, exp_addr, exp_mdata, exp_wreg,
               exp_regwrite, exp_memread, exp_memwrite, exp_halt,
        input  ret_valid, ret_pc, ret_wdata, ret_addr, ret_mdata, ret_wreg,
               ret_regwrite, ret_memread, ret_memwrite, ret_halt,
        output exp_ready
    );

endinterface

// File: rtl/commit_checker_trace_fifo.sv
// Circular FIFO of expected commit records; head is presented combinationally.
module trace_fifo
    import proc_trace_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  commit_rec_t              din,
    output commit_rec_t              dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    commit_rec_t   mem_q [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign full      = (count_q == FULL_CNT);
    assign empty     = (count_q == '0);
    assign occupancy = count_q;
    assign dout      = mem_q[rd_ptr_q];
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/commit_checker.sv
// Lock-step commit checker: compares each retired instruction against a queued expected record.
module commit_checker
    import proc_trace_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    commit_checker_if.slave          bus,
    output logic                     mismatch,
    output logic [4:0]               err_field,
    output logic [15:0]              err_inum,
    output logic [15:0]              inst_count,
    output logic                     done,
    output logic [$clog2(DEPTH):0]   occupancy
);

    state_t      state_q, state_d;
    logic [15:0] inst_count_q, inst_count_d;
    logic [15:0] err_inum_q, err_inum_d;
    logic [4:0]  err_field_q, err_field_d;
    logic        mismatch_q, mismatch_d;
    logic        done_q, done_d;
    logic        ready_q, ready_d;

    commit_rec_t exp_rec;
    commit_rec_t ret_rec;
    commit_rec_t head;
    logic [4:0]  diff;
    logic        full;
    logic        empty;
    logic        push;
    logic        pop;
    logic        exp_ready;

    always_comb begin
        exp_rec.pc       = bus.exp_pc;
        exp_rec.wdata    = bus.exp_wdata;
        exp_rec.addr     = bus.exp_addr;
        exp_rec.mdata    = bus.exp_mdata;
        exp_rec.wreg     = bus.exp_wreg;
        exp_rec.regwrite = bus.exp_regwrite;
        exp_rec.memread  = bus.exp_memread;
        exp_rec.memwrite = bus.exp_memwrite;
        exp_rec.halt     = bus.exp_halt;
        ret_rec.pc       = bus.ret_pc;
        ret_rec.wdata    = bus.ret_wdata;
        ret_rec.addr     = bus.ret_addr;
        ret_rec.mdata    = bus.ret_mdata;
        ret_rec.wreg     = bus.ret_wreg;
        ret_rec.regwrite = bus.ret_regwrite;
        ret_rec.memread  = bus.ret_memread;
        ret_rec.memwrite = bus.ret_memwrite;
        ret_rec.halt     = bus.ret_halt;
    end

    // ready_q keeps exp_ready low through the reset cycle without a combinational path from rst.
    assign exp_ready     = ready_q && (state_q == RUN) && !full;
    assign bus.exp_ready = exp_ready;
    assign push          = bus.exp_valid && exp_ready;
    assign diff          = rec_diff(head, ret_rec);

    trace_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .din       (exp_rec),
        .dout      (head),
        .full      (full),
        .empty     (empty),
        .occupancy (occupancy)
    );

    always_comb begin
        state_d      = state_q;
        inst_count_d = inst_count_q;
        err_inum_d   = err_inum_q;
        err_field_d  = err_field_q;
        mismatch_d   = mismatch_q;
        done_d       = done_q;
        ready_d      = 1'b1;
        pop          = 1'b0;
        if (state_q == RUN && bus.ret_valid) begin
            if (empty) begin
                state_d     = FAIL;
                mismatch_d  = 1'b1;
                err_field_d = 5'b1 << ERR_UNDER;
                err_inum_d  = inst_count_q;
            end else begin
                pop = 1'b1;
                if (diff == '0) begin
                    inst_count_d = inst_count_q + 16'd1;
                    if (head.halt) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end else begin
                    state_d     = FAIL;
                    mismatch_d  = 1'b1;
                    err_field_d = diff;
                    err_inum_d  = inst_count_q;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= RUN;
            inst_count_q <= '0;
            err_inum_q   <= '0;
            err_field_q  <= '0;
            mismatch_q   <= 1'b0;
            done_q       <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            inst_count_q <= inst_count_d;
            err_inum_q   <= err_inum_d;
            err_field_q  <= err_field_d;
            mismatch_q   <= mismatch_d;
            done_q       <= done_d;
            ready_q      <= ready_d;
        end
    end

    assign mismatch   = mismatch_q;
    assign err_field  = err_field_q;
    assign err_inum   = err_inum_q;
    assign inst_count = inst_count_q;
    assign done       = done_q;

endmodule

// File: tb/tb_commit_checker.sv
// Scoreboard bench: each retire queues the expected checker status; a negedge monitor compares it.
module tb_commit_checker;
    import proc_trace_pkg::*;

    typedef struct packed {
        logic        mism;
        logic [4:0]  err;
        logic [15:0] inum;
        logic [15:0] inst;
        logic        dn;
    } status_t;

    logic        clk;
    logic        rst;
    logic        mismatch;
    logic [4:0]  err_field;
    logic [15:0] err_inum;
    logic [15:0] inst_count;
    logic        done;
    logic [2:0]  occupancy;
    logic        pend;

    int checks = 0;
    int errors = 0;
    status_t expQ[$];

    commit_checker_if bus ();

    commit_checker #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .mismatch   (mismatch),
        .err_field  (err_field),
        .err_inum   (err_inum),
        .inst_count (inst_count),
        .done       (done),
        .occupancy  (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Monitor: a retire accepted at a posedge is judged at the following negedge.
    always @(posedge clk) pend <= bus.ret_valid && rst;

    always @(negedge clk) begin
        if (pend) begin
            status_t e;
            status_t a;
            a = '{mism: mismatch, err: err_field, inum: err_inum, inst: inst_count, dn: done};
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL scoreboard: retire seen with no expected status, got %h", a);
            end else begin
                e = expQ.pop_front();
                if (a !== e) begin
                    errors++;
                    $display("[TB] FAIL retire_status: got mism=%b err=%b inum=%0d inst=%0d done=%b, expected mism=%b err=%b inum=%0d inst=%0d done=%b",
                             a.mism, a.err, a.inum, a.inst, a.dn, e.mism, e.err, e.inum, e.inst, e.dn);
                end
            end
        end
    end

    function automatic commit_rec_t mkAlu(input logic [15:0] pc, input logic [2:0] wreg,
                                          input logic [15:0] wdata);
        commit_rec_t r;
        r          = '0;
        r.pc       = pc;
        r.wreg     = wreg;
        r.wdata    = wdata;
        r.regwrite = 1'b1;
        return r;
    endfunction

    function automatic status_t st(input logic m, input logic [4:0] e, input logic [15:0] n,
                                   input logic [15:0] i, input logic d);
        status_t s;
        s = '{mism: m, err: e, inum: n, inst: i, dn: d};
        return s;
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic setExp(input commit_rec_t r);
        bus.exp_pc       = r.pc;
        bus.exp_wdata    = r.wdata;
        bus.exp_addr     = r.addr;
        bus.exp_mdata    = r.mdata;
        bus.exp_wreg     = r.wreg;
        bus.exp_regwrite = r.regwrite;
        bus.exp_memread  = r.memread;
        bus.exp_memwrite = r.memwrite;
        bus.exp_halt     = r.halt;
    endtask

    task automatic setRet(input commit_rec_t r);
        bus.ret_pc       = r.pc;
        bus.ret_wdata    = r.wdata;
        bus.ret_addr     = r.addr;
        bus.ret_mdata    = r.mdata;
        bus.ret_wreg     = r.wreg;
        bus.ret_regwrite = r.regwrite;
        bus.ret_memread  = r.memread;
        bus.ret_memwrite = r.memwrite;
        bus.ret_halt     = r.halt;
    endtask

    // One clock of stimulus: optional offer and/or retire, regardless of exp_ready.
    task automatic applyStimulus(input logic doPush, input commit_rec_t pr,
                                 input logic doRet, input commit_rec_t rr, input status_t s);
        setExp(pr);
        setRet(rr);
        bus.exp_valid = doPush;
        bus.ret_valid = doRet;
        if (doRet) expQ.push_back(s);
        @(posedge clk);
        #1;
        bus.exp_valid = 1'b0;
        bus.ret_valid = 1'b0;
    endtask

    task automatic pushRec(input commit_rec_t r);
        bit ok;
        ok = 1'b0;
        setExp(r);
        bus.exp_valid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (bus.exp_ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.exp_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("[TB] FAIL push_timeout: exp_ready stayed 0, expected 1");
        end
    endtask

    task automatic retire(input commit_rec_t r, input status_t s);
        applyStimulus(1'b0, '0, 1'b1, r, s);
    endtask

    task automatic doReset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    commit_rec_t a [8];
    commit_rec_t h;
    commit_rec_t r;

    initial begin
        bus.exp_valid = 1'b0;
        bus.ret_valid = 1'b0;
        setExp('0);
        setRet('0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_exp_ready", 16'(bus.exp_ready), 16'd0);
        checkOutput("reset_occupancy", 16'(occupancy), 16'd0);
        checkOutput("reset_inst_count", inst_count, 16'd0);
        checkOutput("reset_flags", {11'd0, mismatch, done, 3'd0}, 16'd0);
        checkOutput("reset_err", {11'd0, err_field}, 16'd0);
        checkOutput("reset_err_inum", err_inum, 16'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("release_exp_ready", 16'(bus.exp_ready), 16'd1);

        // Three ALU records then a halt; halt retire carries junk wdata that must be ignored.
        for (int i = 0; i < 3; i++) pushRec(mkAlu(16'(2 * i), 3'(i + 1), 16'h1000 + 16'(i)));
        h      = '0;
        h.pc   = 16'h0006;
        h.halt = 1'b1;
        pushRec(h);
        checkOutput("full_occupancy", 16'(occupancy), 16'd4);
        checkOutput("full_exp_ready", 16'(bus.exp_ready), 16'd0);
        for (int i = 0; i < 3; i++)
            retire(mkAlu(16'(2 * i), 3'(i + 1), 16'h1000 + 16'(i)), st(0, 5'b0, 0, 16'(i + 1), 0));
        r       = h;
        r.wdata = 16'hDEAD;
        retire(r, st(0, 5'b0, 0, 16'd4, 1));
        checkOutput("done_exp_ready", 16'(bus.exp_ready), 16'd0);
        retire(r, st(0, 5'b0, 0, 16'd4, 1));

        // Underflow right after reset.
        doReset();
        retire(mkAlu(16'h0, 3'd1, 16'h0), st(1, 5'b10000, 0, 0, 0));

        // Wrong write data on the third retire.
        doReset();
        for (int i = 0; i < 3; i++) pushRec(mkAlu(16'(2 * i), 3'(i + 1), 16'h1234));
        retire(mkAlu(16'h0, 3'd1, 16'h1234), st(0, 5'b0, 0, 16'd1, 0));
        retire(mkAlu(16'h2, 3'd2, 16'h1234), st(0, 5'b0, 0, 16'd2, 0));
        retire(mkAlu(16'h4, 3'd3, 16'h1235), st(1, 5'b00100, 16'd2, 16'd2, 0));
        checkOutput("fail_exp_ready", 16'(bus.exp_ready), 16'd0);
        checkOutput("fail_occupancy", 16'(occupancy), 16'd0);

        // Full FIFO, held offer, and simultaneous push/pop at occupancy 3 and at full.
        doReset();
        for (int i = 0; i < 8; i++) a[i] = mkAlu(16'h0100 + 16'(2 * i), 3'(i), 16'hA000 + 16'(i));
        for (int i = 0; i < 4; i++) pushRec(a[i]);
        setExp(a[4]);
        bus.exp_valid = 1'b1;
        checkOutput("held_exp_ready", 16'(bus.exp_ready), 16'd0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        bus.exp_valid = 1'b0;
        checkOutput("held_occupancy", 16'(occupancy), 16'd4);
        retire(a[0], st(0, 5'b0, 0, 16'd1, 0));
        checkOutput("pop_occupancy", 16'(occupancy), 16'd3);
        applyStimulus(1'b1, a[4], 1'b1, a[1], st(0, 5'b0, 0, 16'd2, 0));
        checkOutput("pushpop_occupancy", 16'(occupancy), 16'd3);
        pushRec(a[5]);
        applyStimulus(1'b1, a[6], 1'b1, a[2], st(0, 5'b0, 0, 16'd3, 0));
        checkOutput("fullpop_occupancy", 16'(occupancy), 16'd3);
        retire(a[3], st(0, 5'b0, 0, 16'd4, 0));
        retire(a[4], st(0, 5'b0, 0, 16'd5, 0));
        retire(a[5], st(0, 5'b0, 0, 16'd6, 0));
        checkOutput("drain_occupancy", 16'(occupancy), 16'd0);
        retire(a[7], st(1, 5'b10000, 16'd6, 16'd6, 0));

        // Store expected, retired as a non-store with different address/data.
        doReset();
        h          = '0;
        h.pc       = 16'h0020;
        h.memwrite = 1'b1;
        h.addr     = 16'h0010;
        h.mdata    = 16'hBEEF;
        pushRec(h);
        r    = '0;
        r.pc = 16'h0020;
        retire(r, st(1, 5'b01010, 0, 0, 0));

        // Mid-operation reset discards queued records.
        doReset();
        for (int i = 0; i < 4; i++) pushRec(a[i]);
        for (int i = 0; i < 4; i++) retire(a[i], st(0, 5'b0, 0, 16'(i + 1), 0));
        for (int i = 4; i < 7; i++) pushRec(a[i]);
        retire(a[4], st(0, 5'b0, 0, 16'd5, 0));
        checkOutput("pre_reset_occupancy", 16'(occupancy), 16'd2);
        checkOutput("pre_reset_inst_count", inst_count, 16'd5);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("mid_reset_occupancy", 16'(occupancy), 16'd0);
        checkOutput("mid_reset_inst_count", inst_count, 16'd0);
        checkOutput("mid_reset_exp_ready", 16'(bus.exp_ready), 16'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_reset_exp_ready", 16'(bus.exp_ready), 16'd1);
        retire(a[5], st(1, 5'b10000, 0, 0, 0));

        repeat (2) @(posedge clk);
        #1;
        checkOutput("scoreboard_drained", 16'(expQ.size()), 16'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
